mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage plus MEM/WB pipeline register of the hybrid ARM/MIPS pipeline.
- Takes EX/MEM results and performs data-memory and parallel-memory (P) accesses over valid/ack handshakes.
- Registers everything the WriteBack stage consumes: PCSrc, RegWrite, IOFlag, MemToReg, ReadData, ReadDataP, ALUOut, Rd.
- Stalls upstream while an access is outstanding; aborts a hung access by timeout.

Parameters:
TIMEOUT, 16, max cycles waiting for an ack before abort (2..255)

Ports:
clk  in  1  single pipeline clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
ValidM  in  1  EX/MEM holds a live instruction
PCSrcM, RegWriteM, IOFlagM  in  1 each  control from EX/MEM
MemReadM, MemWriteM, MemReadPM  in  1 each  data-mem load/store, P-mem load
MemToRegM  in  2  writeback select, forwarded
ALUOutM  in  32  address / ALU result
WriteDataM  in  32  store data
RdM  in  4  destination register
DReq, DWe  out  1 each  data-mem request, write enable
DAddr, DWData  out  32 each  data-mem address, write data
DRData  in  32  data-mem read data, valid with DAck
DAck  in  1  data-mem completion
PReq  out  1  P-mem request
PAddr  out  32  P-mem address
PRData  in  32  P-mem read data, valid with PAck
PAck  in  1  P-mem completion
StallM  out  1  hold IF..EX/MEM this cycle
MemErr  out  1  one-cycle pulse on timeout abort
PCSrcW, RegWriteW, IOFlagW  out  1 each  to WriteBack
MemToRegW  out  2  to WriteBack
ReadDataW, ReadDataPW, ALUOutW  out  32 each  to WriteBack
RdW  out  4  to WriteBack

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, timeout counter 0.
  - All outputs 0: DReq, PReq, DWe, StallM, MemErr; all *W outputs; DAddr, DWData, PAddr.
- FSM states: IDLE, DWAIT, PWAIT.
- IDLE, ValidM=0:
  - Next edge loads a bubble: RegWriteW=0, PCSrcW=0, IOFlagW=0, other *W fields 0.
  - StallM=0.
- IDLE, ValidM=1, no memory op:
  - Next edge registers PCSrcW/RegWriteW/IOFlagW/MemToRegW/ALUOutW/RdW from the *M inputs.
  - ReadDataW and ReadDataPW = 0. StallM=0. Latency 1 cycle.
- IDLE, ValidM=1, MemReadM or MemWriteM:
  - StallM=1 combinationally in the same cycle.
  - Next edge: DWAIT; DReq=1, DWe=MemWriteM, DAddr=ALUOutM, DWData=WriteDataM.
  - MemReadPM only: same, but enter PWAIT with PReq=1, PAddr=ALUOutM.
- DWAIT:
  - DReq/DAddr/DWData/DWe held stable until DAck. StallM=1 until the DAck cycle.
  - WB regs load a bubble every cycle while waiting.
  - On DAck:
    - Capture DRData into ReadDataW when it was a read (0 for a store); drop DReq.
    - If MemReadPM is also set, go to PWAIT with PReq=1 and StallM held.
    - Otherwise register all *W from the *M inputs and return to IDLE; StallM=0 in the DAck cycle.
- PWAIT:
  - Same rules with PReq/PAck/PRData/ReadDataPW.
  - On PAck: register all *W (ReadDataW keeps its captured value), return to IDLE.
- Inputs: EX/MEM is held stable while StallM=1; the block samples *M inputs directly each cycle, no input copy.
- Timeout:
  - Counter increments each wait cycle and clears on ack or on entering a wait state.
  - When counter==TIMEOUT-1 with no ack: drop the request, pulse MemErr for 1 cycle, return to IDLE.
  - The aborting edge loads the WB regs with RegWriteW=0 and PCSrcW=0, other fields as for normal completion, read data 0.
  - StallM=0 in that abort cycle, so the instruction retires without a write.
- Ack arriving in the same cycle as the timeout limit: the ack wins, normal completion, no MemErr.
- Acks arriving in IDLE, or for the other memory, are ignored.
- rst_n asserted mid-access: immediate return to IDLE, requests drop asynchronously, no WB write.
- Back-to-back: a new memory op may be presented in the first IDLE cycle after completion; no dead cycle required.

Test Plan:
- ALU op: ValidM=1, ALUOutM=0x0000_0042, RdM=5, RegWriteM=1, MemToRegM=1 -> next edge ALUOutW=0x42, RdW=5, RegWriteW=1; StallM never 1.
- Load, DAck after 3 cycles, DRData=0xDEAD_BEEF -> StallM high 4 cycles (issue + 3 waits, low on ack cycle); ReadDataW=0xDEADBEEF on the ack edge; RegWriteW=0 during waits.
- Store: MemWriteM=1, ALUOutM=0x100, WriteDataM=0x1234 -> DReq=1, DWe=1, DAddr=0x100, DWData=0x1234 held stable until DAck; ReadDataW=0.
- Dual read MemReadM=MemReadPM=1: DAck with 0xA, then PAck with 0xB two cycles later -> ReadDataW=0xA and ReadDataPW=0xB in the same WB register load.
- No ack, TIMEOUT=16 -> MemErr pulses exactly once after 16 wait cycles; RegWriteW=0; next instruction proceeds normally.
- rst_n low during DWAIT -> DReq=0 and all *W=0 immediately; after release, the FSM is in IDLE and accepts a new load.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory stage and MEM/WB pipeline register of the hybrid ARM/MIPS pipeline.
//   A live EX/MEM instruction that touches memory issues a data-memory (D)
//   and/or parallel-memory (P) access over a req/ack handshake. The D access
//   always goes first. The upstream pipeline is stalled while an access is
//   outstanding. An access with no ack within TIMEOUT wait cycles is aborted,
//   and the instruction then retires without a register write.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   ValidM, PCSrcM, RegWriteM,
//   IOFlagM, MemReadM, MemWriteM,
//   MemReadPM, MemToRegM, ALUOutM,
//   WriteDataM, RdM                 EX/MEM register contents (held while StallM)
//   DReq, DWe, DAddr, DWData        data-memory request side
//   DRData, DAck                    data-memory response side
//   PReq, PAddr                     P-memory request side
//   PRData, PAck                    P-memory response side
//   StallM                          hold IF..EX/MEM this cycle
//   MemErr                          one-cycle pulse after a timeout abort
//   PCSrcW .. RdW                   MEM/WB register to WriteBack
module mem_access_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ValidM,
   input  logic        PCSrcM,
   input  logic        RegWriteM,
   input  logic        IOFlagM,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic        MemReadPM,
   input  logic [1:0]  MemToRegM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   input  logic [3:0]  RdM,
   output logic        DReq,
   output logic        DWe,
   output logic [31:0] DAddr,
   output logic [31:0] DWData,
   input  logic [31:0] DRData,
   input  logic        DAck,
   output logic        PReq,
   output logic [31:0] PAddr,
   input  logic [31:0] PRData,
   input  logic        PAck,
   output logic        StallM,
   output logic        MemErr,
   output logic        PCSrcW,
   output logic        RegWriteW,
   output logic        IOFlagW,
   output logic [1:0]  MemToRegW,
   output logic [31:0] ReadDataW,
   output logic [31:0] ReadDataPW,
   output logic [31:0] ALUOutW,
   output logic [3:0]  RdW
);

   localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_DWAIT, S_PWAIT} state_t;

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic [31:0] r_dcap, w_dcap_nxt;   // D read data held while the P access runs
   logic        w_dreq_nxt, w_dwe_nxt, w_preq_nxt, w_memerr_nxt;
   logic [31:0] w_daddr_nxt, w_dwdata_nxt, w_paddr_nxt;
   logic        w_stall, w_retire, w_kill, w_timeout;
   logic [31:0] w_rd_nxt, w_rdp_nxt;

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = '0;
      w_dcap_nxt   = r_dcap;
      w_dreq_nxt   = DReq;
      w_dwe_nxt    = DWe;
      w_daddr_nxt  = DAddr;
      w_dwdata_nxt = DWData;
      w_preq_nxt   = PReq;
      w_paddr_nxt  = PAddr;
      w_memerr_nxt = 1'b0;
      w_stall      = 1'b0;
      w_retire     = 1'b0;
      w_kill       = 1'b0;
      w_rd_nxt     = '0;
      w_rdp_nxt    = '0;
      w_timeout    = (r_cnt == LP_LIMIT);
      case (r_state)
         S_IDLE: begin
            w_dcap_nxt = '0;
            if (ValidM) begin
               if (MemReadM || MemWriteM) begin
                  w_stall      = 1'b1;
                  w_state_nxt  = S_DWAIT;
                  w_dreq_nxt   = 1'b1;
                  w_dwe_nxt    = MemWriteM;
                  w_daddr_nxt  = ALUOutM;
                  w_dwdata_nxt = WriteDataM;
               end else if (MemReadPM) begin
                  w_stall     = 1'b1;
                  w_state_nxt = S_PWAIT;
                  w_preq_nxt  = 1'b1;
                  w_paddr_nxt = ALUOutM;
               end else begin
                  w_retire = 1'b1;
               end
            end
         end
         S_DWAIT: begin
            if (DAck) begin
               w_dreq_nxt = 1'b0;
               w_dwe_nxt  = 1'b0;
               w_dcap_nxt = MemReadM ? DRData : '0;
               if (MemReadPM) begin
                  w_stall     = 1'b1;
                  w_state_nxt = S_PWAIT;
                  w_preq_nxt  = 1'b1;
                  w_paddr_nxt = ALUOutM;
               end else begin
                  w_retire    = 1'b1;
                  w_rd_nxt    = MemReadM ? DRData : '0;
                  w_state_nxt = S_IDLE;
               end
            end else if (w_timeout) begin
               // Abort: release the stall so the instruction retires as a no-write.
               w_dreq_nxt   = 1'b0;
               w_dwe_nxt    = 1'b0;
               w_memerr_nxt = 1'b1;
               w_retire     = 1'b1;
               w_kill       = 1'b1;
               w_state_nxt  = S_IDLE;
            end else begin
               w_stall   = 1'b1;
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         S_PWAIT: begin
            if (PAck) begin
               w_preq_nxt  = 1'b0;
               w_retire    = 1'b1;
               w_rd_nxt    = r_dcap;
               w_rdp_nxt   = PRData;
               w_state_nxt = S_IDLE;
            end else if (w_timeout) begin
               w_preq_nxt   = 1'b0;
               w_memerr_nxt = 1'b1;
               w_retire     = 1'b1;
               w_kill       = 1'b1;
               w_state_nxt  = S_IDLE;
            end else begin
               w_stall   = 1'b1;
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Reset forces the stall low even while a memory op sits in EX/MEM.
   assign StallM = w_stall & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_dcap     <= '0;
         DReq       <= 1'b0;
         DWe        <= 1'b0;
         DAddr      <= '0;
         DWData     <= '0;
         PReq       <= 1'b0;
         PAddr      <= '0;
         MemErr     <= 1'b0;
         PCSrcW     <= 1'b0;
         RegWriteW  <= 1'b0;
         IOFlagW    <= 1'b0;
         MemToRegW  <= '0;
         ReadDataW  <= '0;
         ReadDataPW <= '0;
         ALUOutW    <= '0;
         RdW        <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dcap  <= w_dcap_nxt;
         DReq    <= w_dreq_nxt;
         DWe     <= w_dwe_nxt;
         DAddr   <= w_daddr_nxt;
         DWData  <= w_dwdata_nxt;
         PReq    <= w_preq_nxt;
         PAddr   <= w_paddr_nxt;
         MemErr  <= w_memerr_nxt;
         if (w_retire) begin
            PCSrcW     <= PCSrcM & ~w_kill;
            RegWriteW  <= RegWriteM & ~w_kill;
            IOFlagW    <= IOFlagM;
            MemToRegW  <= MemToRegM;
            ReadDataW  <= w_rd_nxt;
            ReadDataPW <= w_rdp_nxt;
            ALUOutW    <= ALUOutM;
            RdW        <= RdM;
         end else begin
            PCSrcW     <= 1'b0;
            RegWriteW  <= 1'b0;
            IOFlagW    <= 1'b0;
            MemToRegW  <= '0;
            ReadDataW  <= '0;
            ReadDataPW <= '0;
            ALUOutW    <= '0;
            RdW        <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
//   Drives EX/MEM instructions and plays both memories. For each instruction
//   the expected WriteBack record is derived from the instruction kind and
//   the chosen ack latencies and queued; a monitor pops and compares it one
//   cycle after the instruction leaves EX/MEM (ValidM high, StallM low).
module tb_mem_access_stage;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ValidM = 1'b0, PCSrcM = 1'b0, RegWriteM = 1'b0, IOFlagM = 1'b0;
   logic        MemReadM = 1'b0, MemWriteM = 1'b0, MemReadPM = 1'b0;
   logic [1:0]  MemToRegM = '0;
   logic [31:0] ALUOutM = '0, WriteDataM = '0;
   logic [3:0]  RdM = '0;
   logic        DReq, DWe, PReq, StallM, MemErr;
   logic [31:0] DAddr, DWData, PAddr;
   logic [31:0] DRData = '0, PRData = '0;
   logic        DAck = 1'b0, PAck = 1'b0;
   logic        PCSrcW, RegWriteW, IOFlagW;
   logic [1:0]  MemToRegW;
   logic [31:0] ReadDataW, ReadDataPW, ALUOutW;
   logic [3:0]  RdW;

   mem_access_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .ValidM(ValidM), .PCSrcM(PCSrcM),
      .RegWriteM(RegWriteM), .IOFlagM(IOFlagM), .MemReadM(MemReadM),
      .MemWriteM(MemWriteM), .MemReadPM(MemReadPM), .MemToRegM(MemToRegM),
      .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .RdM(RdM),
      .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
      .DRData(DRData), .DAck(DAck), .PReq(PReq), .PAddr(PAddr),
      .PRData(PRData), .PAck(PAck), .StallM(StallM), .MemErr(MemErr),
      .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .IOFlagW(IOFlagW),
      .MemToRegW(MemToRegW), .ReadDataW(ReadDataW), .ReadDataPW(ReadDataPW),
      .ALUOutW(ALUOutW), .RdW(RdW)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pc, rw, io, err;
      logic [1:0]  m2r;
      logic [31:0] rd, rdp, alu;
      logic [3:0]  rdst;
   } wb_t;

   wb_t exp_q[$];
   wb_t m_e;
   int  total = 0;
   int  bad   = 0;
   logic pend = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: compare the MEM/WB register one cycle after a retirement.
   always @(negedge clk) begin
      if (pend) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_retire: got retirement want none at %0t", $time);
         end else begin
            m_e = exp_q.pop_front();
            chk("PCSrcW", {31'd0, PCSrcW}, {31'd0, m_e.pc});
            chk("RegWriteW", {31'd0, RegWriteW}, {31'd0, m_e.rw});
            chk("IOFlagW", {31'd0, IOFlagW}, {31'd0, m_e.io});
            chk("MemToRegW", {30'd0, MemToRegW}, {30'd0, m_e.m2r});
            chk("ReadDataW", ReadDataW, m_e.rd);
            chk("ReadDataPW", ReadDataPW, m_e.rdp);
            chk("ALUOutW", ALUOutW, m_e.alu);
            chk("RdW", {28'd0, RdW}, {28'd0, m_e.rdst});
            chk("MemErr", {31'd0, MemErr}, {31'd0, m_e.err});
         end
      end else if (rst_n) begin
         chk("bubble_RegWriteW", {31'd0, RegWriteW}, 32'd0);
         chk("bubble_PCSrcW", {31'd0, PCSrcW}, 32'd0);
         chk("MemErr_quiet", {31'd0, MemErr}, 32'd0);
      end
      pend = rst_n && ValidM && !StallM;
   end

   // kind: 0 ALU, 1 load, 2 store, 3 load+P, 4 P only, 5 store+P
   // ld/lp: wait cycles before the D/P ack (>= TO means never acked)
   task automatic do_op(input int kind, input int ld, input int lp,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] dv, input logic [31:0] pv,
                        input logic [3:0] rd, input logic rw, input logic pc,
                        input logic io, input logic [1:0] m2r);
      logic d, p, dread, dwr, dok, pok, ack, exp_s;
      wb_t  e;
      d     = kind inside {1, 2, 3, 5};
      p     = kind inside {3, 4, 5};
      dread = kind inside {1, 3};
      dwr   = kind inside {2, 5};
      dok   = !d || (ld < TO);
      pok   = !p || (dok && (lp < TO));
      e.err  = !(dok && pok);
      e.pc   = e.err ? 1'b0 : pc;
      e.rw   = e.err ? 1'b0 : rw;
      e.io   = io;
      e.m2r  = m2r;
      e.alu  = alu;
      e.rdst = rd;
      e.rd   = (e.err || !dread) ? 32'd0 : dv;
      e.rdp  = (e.err || !p) ? 32'd0 : pv;
      exp_q.push_back(e);

      ValidM = 1'b1; PCSrcM = pc; RegWriteM = rw; IOFlagM = io;
      MemReadM = dread; MemWriteM = dwr; MemReadPM = p; MemToRegM = m2r;
      ALUOutM = alu; WriteDataM = wd; RdM = rd;
      @(negedge clk);
      chk("StallM_issue", {31'd0, StallM}, {31'd0, (d || p)});
      @(posedge clk); #1;

      if (d) begin
         for (int w = 0; w < TO; w++) begin
            ack    = (w == ld);
            DAck   = ack;
            DRData = ack ? dv : $urandom;
            PAck   = ($urandom_range(0, 3) == 0);
            PRData = $urandom;
            @(negedge clk);
            chk("DReq", {31'd0, DReq}, 32'd1);
            chk("DWe", {31'd0, DWe}, {31'd0, dwr});
            chk("DAddr", DAddr, alu);
            chk("DWData", DWData, wd);
            chk("PReq_in_dwait", {31'd0, PReq}, 32'd0);
            exp_s = ack ? p : (w != TO - 1);
            chk("StallM_dwait", {31'd0, StallM}, {31'd0, exp_s});
            @(posedge clk); #1;
            DAck = 1'b0;
            PAck = 1'b0;
            if (ack) break;
         end
      end

      if (p && dok) begin
         for (int w = 0; w < TO; w++) begin
            ack    = (w == lp);
            PAck   = ack;
            PRData = ack ? pv : $urandom;
            DAck   = ($urandom_range(0, 3) == 0);
            DRData = $urandom;
            @(negedge clk);
            chk("PReq", {31'd0, PReq}, 32'd1);
            chk("PAddr", PAddr, alu);
            chk("DReq_in_pwait", {31'd0, DReq}, 32'd0);
            exp_s = ack ? 1'b0 : (w != TO - 1);
            chk("StallM_pwait", {31'd0, StallM}, {31'd0, exp_s});
            @(posedge clk); #1;
            DAck = 1'b0;
            PAck = 1'b0;
            if (ack) break;
         end
      end
      ValidM = 1'b0;
   endtask

   // Idle cycles with junk on the EX/MEM fields and stray acks.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         ValidM = 1'b0;
         MemReadM = 1'($urandom); MemWriteM = 1'($urandom); MemReadPM = 1'($urandom);
         RegWriteM = 1'($urandom); PCSrcM = 1'($urandom); ALUOutM = $urandom;
         DAck = 1'($urandom); PAck = 1'($urandom);
         DRData = $urandom; PRData = $urandom;
         @(posedge clk); #1;
      end
      DAck = 1'b0;
      PAck = 1'b0;
   endtask

   function automatic int pick_lat();
      int r;
      r = int'($urandom_range(0, 11));
      if (r == 0) return 99;
      if (r == 1) return TO - 1;
      return int'($urandom_range(0, 4));
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      #12;
      chk("rst_DReq", {31'd0, DReq}, 32'd0);
      chk("rst_PReq", {31'd0, PReq}, 32'd0);
      chk("rst_DWe", {31'd0, DWe}, 32'd0);
      chk("rst_StallM", {31'd0, StallM}, 32'd0);
      chk("rst_MemErr", {31'd0, MemErr}, 32'd0);
      chk("rst_DAddr", DAddr, 32'd0);
      chk("rst_DWData", DWData, 32'd0);
      chk("rst_PAddr", PAddr, 32'd0);
      chk("rst_RegWriteW", {31'd0, RegWriteW}, 32'd0);
      chk("rst_ReadDataW", ReadDataW, 32'd0);
      chk("rst_ALUOutW", ALUOutW, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);

      // directed cases
      do_op(0, 0, 0, 32'h42, 32'h0, 32'h0, 32'h0, 4'd5, 1'b1, 1'b0, 1'b0, 2'd1);
      do_op(1, 3, 0, 32'h200, 32'h0, 32'hDEAD_BEEF, 32'h0, 4'd3, 1'b1, 1'b0, 1'b0, 2'd1);
      do_op(2, 2, 0, 32'h100, 32'h1234, 32'h5555, 32'h0, 4'd7, 1'b0, 1'b0, 1'b0, 2'd0);
      do_op(3, 0, 1, 32'h300, 32'h0, 32'hA, 32'hB, 4'd9, 1'b1, 1'b0, 1'b1, 2'd2);
      do_op(1, 99, 0, 32'h400, 32'h0, 32'h77, 32'h0, 4'd2, 1'b1, 1'b1, 1'b0, 2'd1);
      do_op(0, 0, 0, 32'h55, 32'h0, 32'h0, 32'h0, 4'd6, 1'b1, 1'b1, 1'b0, 2'd0);
      do_op(1, TO - 1, 0, 32'h500, 32'h0, 32'hCAFE, 32'h0, 4'd4, 1'b1, 1'b0, 1'b0, 2'd1);
      do_op(4, 0, 99, 32'h600, 32'h0, 32'h0, 32'h99, 4'd8, 1'b1, 1'b0, 1'b0, 2'd3);
      idle(1);

      // reset in the middle of a data-memory wait
      ValidM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; MemReadPM = 1'b0;
      RegWriteM = 1'b1; ALUOutM = 32'h700; RdM = 4'd1;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      ValidM = 1'b0; MemReadM = 1'b0;
      #1;
      chk("midrst_DReq", {31'd0, DReq}, 32'd0);
      chk("midrst_DAddr", DAddr, 32'd0);
      chk("midrst_StallM", {31'd0, StallM}, 32'd0);
      chk("midrst_RegWriteW", {31'd0, RegWriteW}, 32'd0);
      chk("midrst_ReadDataW", ReadDataW, 32'd0);
      chk("midrst_RdW", {28'd0, RdW}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_op(1, 1, 0, 32'h800, 32'h0, 32'h1357_9BDF, 32'h0, 4'd11, 1'b1, 1'b0, 1'b0, 2'd1);

      // randomized back-to-back traffic
      for (int n = 0; n < 150; n++) begin
         do_op(int'($urandom_range(0, 5)), pick_lat(), pick_lat(), $urandom, $urandom,
               $urandom, $urandom, 4'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 2'($urandom));
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end

      idle(3);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
